// File: rtl/addsub_acc_pkg.sv
// Shared constants for the add/subtract accumulator: digit count, legal width
// range and the active-low seven-segment hex encoding (bit 6 = segment a).
package addsub_acc_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int DISP_W     = 4 * NUM_DIGITS;
    localparam int W_MIN      = 1;
    localparam int W_MAX      = 8;

    localparam logic [6:0] SEG_0 = 7'b0000001;
    localparam logic [6:0] SEG_1 = 7'b1001111;
    localparam logic [6:0] SEG_2 = 7'b0010010;
    localparam logic [6:0] SEG_3 = 7'b0000110;
    localparam logic [6:0] SEG_4 = 7'b1001100;
    localparam logic [6:0] SEG_5 = 7'b0100100;
    localparam logic [6:0] SEG_6 = 7'b0100000;
    localparam logic [6:0] SEG_7 = 7'b0001111;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0000100;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b1100000;
    localparam logic [6:0] SEG_C = 7'b0110001;
    localparam logic [6:0] SEG_D = 7'b1000010;
    localparam logic [6:0] SEG_E = 7'b0110000;
    localparam logic [6:0] SEG_F = 7'b0111000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = SEG_0;
            4'h1:    seg = SEG_1;
            4'h2:    seg = SEG_2;
            4'h3:    seg = SEG_3;
            4'h4:    seg = SEG_4;
            4'h5:    seg = SEG_5;
            4'h6:    seg = SEG_6;
            4'h7:    seg = SEG_7;
            4'h8:    seg = SEG_8;
            4'h9:    seg = SEG_9;
            4'hA:    seg = SEG_A;
            4'hB:    seg = SEG_B;
            4'hC:    seg = SEG_C;
            4'hD:    seg = SEG_D;
            4'hE:    seg = SEG_E;
            4'hF:    seg = SEG_F;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/addsub_acc_seg_scan.sv
// Multiplexed 4-digit seven-segment driver: free-running scan counter, digit
// mux, hex decode and registered active-low a_to_g / an / dp pins.
module seg_scan
    import addsub_acc_pkg::*;
#(
    parameter int SCAN_DIV = 18
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic [DISP_W-1:0]     value,
    input  logic [NUM_DIGITS-1:0] dp_mask,
    output logic [6:0]            a_to_g,
    output logic [NUM_DIGITS-1:0] an,
    output logic                  dp
);

    logic [SCAN_DIV-1:0]   scan_q, scan_d;
    logic [1:0]            sel_s;
    logic [3:0]            nib_s;
    logic [6:0]            seg_q, seg_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic                  dp_q, dp_d;

    // Select the digit from the scan counter's top two bits and decode it.
    always_comb begin
        scan_d = scan_q + SCAN_DIV'(1);
        sel_s  = scan_q[SCAN_DIV-1 -: 2];
        nib_s  = value[3:0];
        an_d   = 4'b1111;
        case (sel_s)
            2'd0: begin nib_s = value[3:0];   an_d = 4'b1110; end
            2'd1: begin nib_s = value[7:4];   an_d = 4'b1101; end
            2'd2: begin nib_s = value[11:8];  an_d = 4'b1011; end
            2'd3: begin nib_s = value[15:12]; an_d = 4'b0111; end
            default: begin nib_s = value[3:0]; an_d = 4'b1111; end
        endcase
        seg_d = hex_to_seg(nib_s);
        dp_d  = ~dp_mask[sel_s];
    end

    // Scan counter and pin registers; reset shows digit 0 with value zero.
    always_ff @(posedge clk) begin
        if (clr) begin
            scan_q <= '0;
            seg_q  <= SEG_0;
            an_q   <= 4'b1110;
            dp_q   <= 1'b1;
        end else begin
            scan_q <= scan_d;
            seg_q  <= seg_d;
            an_q   <= an_d;
            dp_q   <= dp_d;
        end
    end

    assign a_to_g = seg_q;
    assign an     = an_q;
    assign dp     = dp_q;

endmodule

// File: rtl/addsub_acc_top.sv
// Board-level add/subtract accumulator with debounced load/step buttons and a
// multiplexed hex display. Define ADDSUB_ACC_OVF_EN to build signed overflow on digit-2 dp.
module addsub_acc_top
    import addsub_acc_pkg::*;
#(
    parameter int W          = 4,
    parameter int DEB_CYCLES = 500000,
    parameter int SCAN_DIV   = 18
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic [2*W-1:0]        sw,
    input  logic                  sub,
    input  logic                  btn_load,
    input  logic                  btn_step,
    output logic [6:0]            a_to_g,
    output logic [NUM_DIGITS-1:0] an,
    output logic                  dp
);

    localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic [W-1:0] op_a_s, op_b_s;
    logic [1:0]   btn_raw_s, btn_pulse_s;
    logic         load_s, step_s;

    assign op_a_s    = sw[2*W-1:W];
    assign op_b_s    = sw[W-1:0];
    assign btn_raw_s = {btn_step, btn_load};
    assign load_s    = btn_pulse_s[0];
    assign step_s    = btn_pulse_s[1];

    // Each button: 2-FF sync, stability counter, then a registered rising-edge pulse.
    for (genvar i = 0; i < 2; i++) begin : g_deb
        logic             sync1_q, sync1_d;
        logic             sync2_q, sync2_d;
        logic             lvl_q, lvl_d;
        logic             lvl_dly_q, lvl_dly_d;
        logic             pulse_q, pulse_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;

        // The counter only runs while the synced level disagrees with the
        // accepted one, so any bounce back to the accepted level restarts it.
        always_comb begin
            sync1_d   = btn_raw_s[i];
            sync2_d   = sync1_q;
            lvl_d     = lvl_q;
            cnt_d     = '0;
            if (sync2_q != lvl_q) begin
                if (cnt_q == CNT_LAST) begin
                    lvl_d = sync2_q;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end else begin
                cnt_d = '0;
            end
            lvl_dly_d = lvl_q;
            pulse_d   = lvl_q & ~lvl_dly_q;
        end

        // Debouncer state registers.
        always_ff @(posedge clk) begin
            if (clr) begin
                sync1_q   <= 1'b0;
                sync2_q   <= 1'b0;
                lvl_q     <= 1'b0;
                lvl_dly_q <= 1'b0;
                pulse_q   <= 1'b0;
                cnt_q     <= '0;
            end else begin
                sync1_q   <= sync1_d;
                sync2_q   <= sync2_d;
                lvl_q     <= lvl_d;
                lvl_dly_q <= lvl_dly_d;
                pulse_q   <= pulse_d;
                cnt_q     <= cnt_d;
            end
        end

        assign btn_pulse_s[i] = pulse_q;
    end

    logic [W-1:0] acc_q, acc_d;
    logic         cf_q, cf_d;
    logic [W-1:0] step_res_s;
    logic         step_c_s;
    logic         ovf_s;

    // Step result: W+1-bit sum, or difference whose top bit is the borrow.
    always_comb begin
        if (sub) begin
            {step_c_s, step_res_s} = {1'b0, acc_q} - {1'b0, op_b_s};
        end else begin
            {step_c_s, step_res_s} = {1'b0, acc_q} + {1'b0, op_b_s};
        end
    end

    // Load has priority over a coincident step.
    always_comb begin
        acc_d = acc_q;
        cf_d  = cf_q;
        if (load_s) begin
            acc_d = op_a_s;
            cf_d  = 1'b0;
        end else if (step_s) begin
            acc_d = step_res_s;
            cf_d  = step_c_s;
        end else begin
            acc_d = acc_q;
            cf_d  = cf_q;
        end
    end

    // Accumulator and carry/borrow flag.
    always_ff @(posedge clk) begin
        if (clr) begin
            acc_q <= '0;
            cf_q  <= 1'b0;
        end else begin
            acc_q <= acc_d;
            cf_q  <= cf_d;
        end
    end

`ifdef ADDSUB_ACC_OVF_EN
    logic ovf_q, ovf_d;

    // Signed overflow from operand and result sign bits.
    always_comb begin
        ovf_d = ovf_q;
        if (load_s) begin
            ovf_d = 1'b0;
        end else if (step_s) begin
            if (sub) begin
                ovf_d = (acc_q[W-1] != op_b_s[W-1]) && (step_res_s[W-1] != acc_q[W-1]);
            end else begin
                ovf_d = (acc_q[W-1] == op_b_s[W-1]) && (step_res_s[W-1] != acc_q[W-1]);
            end
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Overflow flag register.
    always_ff @(posedge clk) begin
        if (clr) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf_s = ovf_q;
`else
    assign ovf_s = 1'b0;
`endif

    logic [DISP_W-1:0]     disp_s;
    logic [NUM_DIGITS-1:0] dp_mask_s;

    // Display word {B, acc}, each zero-extended to a byte; dp on digits 0 and 2.
    always_comb begin
        disp_s                 = '0;
        disp_s[W-1:0]          = acc_q;
        disp_s[W_MAX +: W]     = op_b_s;
        dp_mask_s              = {1'b0, ovf_s, 1'b0, cf_q};
    end

    seg_scan #(
        .SCAN_DIV (SCAN_DIV)
    ) u_seg_scan (
        .clk     (clk),
        .clr     (clr),
        .value   (disp_s),
        .dp_mask (dp_mask_s),
        .a_to_g  (a_to_g),
        .an      (an),
        .dp      (dp)
    );

endmodule

// File: tb/tb_addsub_acc_top.sv
// Randomized and directed bench for addsub_acc_top (W=4, DEB_CYCLES=4, SCAN_DIV=4);
// the accumulator is observed only through the multiplexed display pins.
module tb_addsub_acc_top;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic [7:0] sw = 8'h00;
    logic       sub = 1'b0;
    logic       btn_load = 1'b0;
    logic       btn_step = 1'b0;
    logic [6:0] a_to_g;
    logic [3:0] an;
    logic       dp;

    int n_cmp = 0;
    int n_bad = 0;

    int  m_acc = 0;
    bit  m_cf  = 1'b0;
    bit  m_ovf = 1'b0;

    logic [6:0] seg_tab [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                                 7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

    addsub_acc_top #(.W(4), .DEB_CYCLES(4), .SCAN_DIV(4)) dut (
        .clk      (clk),
        .clr      (clr),
        .sw       (sw),
        .sub      (sub),
        .btn_load (btn_load),
        .btn_step (btn_step),
        .a_to_g   (a_to_g),
        .an       (an),
        .dp       (dp)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int to_signed4(input int v);
        return (v >= 8) ? v - 16 : v;
    endfunction

    task automatic model_load(input int a);
        m_acc = a;
        m_cf  = 1'b0;
        m_ovf = 1'b0;
    endtask

    task automatic model_step(input int b, input bit s);
        int r, sr;
        if (!s) begin
            r     = m_acc + b;
            m_cf  = (r > 15);
            sr    = to_signed4(m_acc) + to_signed4(b);
            m_acc = r % 16;
        end else begin
            m_cf  = (m_acc < b);
            sr    = to_signed4(m_acc) - to_signed4(b);
            m_acc = (m_acc - b + 16) % 16;
        end
        m_ovf = (sr < -8) || (sr > 7);
    endtask

    task automatic press(input bit do_load, input bit do_step, input int hold);
        @(negedge clk);
        btn_load = do_load;
        btn_step = do_step;
        repeat (hold) @(negedge clk);
        btn_load = 1'b0;
        btn_step = 1'b0;
        repeat (20) @(negedge clk);
    endtask

    task automatic check_display(input string tag);
        logic [3:0] target;
        int nib, exp_dp;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            target = ~(4'b0001 << k);
            for (int t = 0; t < 40; t++) begin
                if (an == target) break;
                @(negedge clk);
            end
            chk({tag, "_an"}, 32'(an), 32'(target));
            case (k)
                0:       nib = m_acc;
                2:       nib = int'(sw[3:0]);
                default: nib = 0;
            endcase
            exp_dp = 1;
            if (k == 0 && m_cf) exp_dp = 0;
`ifdef ADDSUB_ACC_OVF_EN
            if (k == 2 && m_ovf) exp_dp = 0;
`endif
            chk({tag, "_seg"}, 32'(a_to_g), 32'(seg_tab[nib]));
            chk({tag, "_dp"}, 32'(dp), 32'(exp_dp));
            @(negedge clk);
        end
    endtask

    initial begin
        int op, a, b;
        bit s;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_an", 32'(an), 32'(4'b1110));
        chk("rst_seg", 32'(a_to_g), 32'(7'b0000001));
        chk("rst_dp", 32'(dp), 32'(1));
        clr = 1'b0;
        check_display("rst");

        // Load A=5, B=3
        sw = {4'd5, 4'd3};
        press(1'b1, 1'b0, 20);
        model_load(5);
        check_display("load5");

        // 9 + 8: carry and signed overflow
        sw = {4'd9, 4'd8};
        press(1'b1, 1'b0, 20);
        model_load(9);
        sub = 1'b0;
        press(1'b0, 1'b1, 20);
        model_step(8, 1'b0);
        check_display("add98");

        // 3 - 5: borrow, no overflow
        sw = {4'd3, 4'd5};
        press(1'b1, 1'b0, 20);
        model_load(3);
        sub = 1'b1;
        press(1'b0, 1'b1, 20);
        model_step(5, 1'b1);
        check_display("sub35");

        // Bouncy press then hold: exactly one step
        sw = {4'd0, 4'd2};
        sub = 1'b0;
        press(1'b1, 1'b0, 20);
        model_load(0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); btn_step = 1'b1;
            @(negedge clk); btn_step = 1'b0;
        end
        press(1'b0, 1'b1, 20);
        model_step(2, 1'b0);
        check_display("bounce");

        // Short glitch: no step
        press(1'b0, 1'b1, 3);
        check_display("glitch");

        // Coincident load and step: load wins
        sw = {4'd2, 4'd1};
        press(1'b1, 1'b1, 20);
        model_load(2);
        check_display("both");

        // clr mid-debounce, released before re-qualifying: nothing
        sw = {4'd7, 4'd3};
        @(negedge clk); btn_step = 1'b1;
        repeat (2) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        repeat (2) @(negedge clk);
        btn_step = 1'b0;
        repeat (20) @(negedge clk);
        model_load(0);
        check_display("clr_rel");

        // clr mid-debounce, held afterwards: re-qualifies to one step
        @(negedge clk); btn_step = 1'b1;
        repeat (2) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        repeat (20) @(negedge clk);
        btn_step = 1'b0;
        repeat (20) @(negedge clk);
        model_step(3, 1'b0);
        check_display("clr_hold");

        // Random operations; switches scrambled afterwards must not disturb acc
        for (int i = 0; i < 16; i++) begin
            op = $urandom_range(0, 2);
            a  = $urandom_range(0, 15);
            b  = $urandom_range(0, 15);
            s  = (op == 2);
            sw  = 8'((a << 4) | b);
            sub = s;
            if (op == 0) begin
                press(1'b1, 1'b0, 12);
                model_load(a);
            end else begin
                press(1'b0, 1'b1, 12);
                model_step(b, s);
            end
            sw  = 8'($urandom_range(0, 255));
            sub = 1'($urandom_range(0, 1));
            check_display($sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/addsub_acc_top.md
# addsub_acc_top

Parametrised board-level add/subtract accumulator with integrated multiplexed 4-digit seven-segment display. Operand B comes from switches; debounced button presses load operand A into the accumulator or step it by ±B, with carry/borrow (and optionally signed overflow) shown on decimal points. It is the top-level successor to the fixed 4-bit switch adder demo.

## Interface
Parameters:
- W, 4: operand/accumulator width, legal 1..8
- DEB_CYCLES, 500000: cycles a synchronised button must hold steady before it is accepted (≥2)
- SCAN_DIV, 18: display scan counter width; digit select = top 2 bits (≥3)

Ports:
- clk  in  1  system clock
- clr  in  1  synchronous, active-high reset
- sw  in  2*W  sw[2W-1:W] = operand A, sw[W-1:0] = operand B
- sub  in  1  0 = step adds B, 1 = step subtracts B (sampled on step pulse)
- btn_load  in  1  raw button: acc ← A
- btn_step  in  1  raw button: acc ← acc ± B
- a_to_g  out  7  segments a..g, active low, bit 6 = a
- an  out  4  digit enables, active low, an[0] = rightmost
- dp  out  1  decimal point, active low

## Operation
- Each button: 2-FF synchroniser → debounce counter (restarts on any change of synchronised level; accepts new level after DEB_CYCLES stable cycles) → rising-edge detect → 1-cycle pulse.
- On load pulse: acc ← A; cf ← 0; ovf ← 0.
- On step pulse, add: {cf, acc} ← acc + B (W+1-bit sum). Sub: acc ← acc − B mod 2^W; cf ← 1 iff acc < B (borrow).
- ovf (see Configuration): add: sign(acc)=sign(B)≠sign(result); sub: sign(acc)≠sign(B) and sign(result)≠sign(acc). Sign = bit W-1.
- Load and step pulse same cycle: load wins, step discarded.
- sw/sub changing between pulses has no effect on acc.
- Display word D[15:0] = {B zero-extended to 8 bits, acc zero-extended to 8 bits}; digit k shows hex of D[4k+3:4k], digits 0..3 cycled by scan counter.
- dp low on digit 0 when cf=1; dp low on digit 2 when ovf=1 (if enabled); otherwise high.
- Reset: acc=0, cf=0, ovf=0, debouncers idle at level 0, scan counter 0, so an=4'b1110, a_to_g=7'b0000001, dp=1.

## Timing
- Button edge to acc update: 2 (sync) + DEB_CYCLES + 1 (edge) + 1 (register) cycles.
- Held button produces exactly one pulse; release produces none.
- Display outputs registered: 1-cycle lag from scan count/acc to pins.
- Digit dwell = 2^(SCAN_DIV-2) cycles; full refresh = 2^SCAN_DIV cycles; wraps freely.
- clr asserted mid-debounce or mid-scan: all state to reset values next edge; a press in progress must be re-qualified for full DEB_CYCLES after clr drops.

## Configuration
- ADDSUB_ACC_OVF_EN defined: ovf register and digit-2 dp indication built.
- Not defined: no ovf logic; digit-2 dp constant high (off); cf behaviour unchanged.

## Structure
- Shared package/include: 7-segment hex encoding constants (0–F, active-low), digit count (4), W legal range.
- One sub-module: seg_scan — scan counter, digit mux, hex decode, registered a_to_g/an/dp; takes 16-bit value and 4-bit dp mask.
- Debouncer instantiated twice as an internal block or generate loop inside the top; no separate file required.

## Test plan
(W=4, DEB_CYCLES=4, SCAN_DIV=4)
- clr 3 cycles → an=1110, a_to_g=0000001, dp=1; acc=0 on every digit scan.
- A=5, load press → acc=5; digit0 shows 5, digit2 shows B; cf=0.
- acc=9, B=8, sub=0, step → acc=1, cf=1 (digit0 dp low); ovf=1 (9+8: −7+−8 wraps) with macro, digit2 dp high without.
- acc=3, B=5, sub=1, step → acc=E, cf=1; ovf=0.
- btn_step bounces 1 cycle high/low ×3 then held 20 cycles → exactly one step; glitch shorter than DEB_CYCLES → none.
- load and step pulses aligned same cycle with A=2, B=1 → acc=2; clr mid-debounce → no update after release.
